// File: rtl/status_register.sv
// status_register: processor status byte (N V 1 B D I Z C) with NMI edge / IRQ level request logic.
// Build option STATUS_SYNC_EN inserts two-flop synchronizers on nmi_n and irq_n.
module status_register (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] flags_out,
  input  logic [7:0] flags_ena,
  input  logic       pl_load,
  input  logic [7:0] pl_data,
  input  logic       brk_push,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       instr_done,
  input  logic       int_ack,
  output logic [7:0] flags_in,
  output logic [7:0] push_data,
  output logic       int_req,
  output logic       int_vec_sel
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;

  localparam logic [7:0] P_RESET = 8'h34;
  localparam logic [7:0] P_WMASK = 8'hCF;
  localparam logic [7:0] P_ONES  = 8'h30;

  state_e     state_q, state_d;
  logic [7:0] p_q, p_d;
  logic [7:0] p_upd;
  logic       nmi_q, nmi_d;
  logic       nmi_pend_q, nmi_pend_d;
  logic       int_vec_sel_q, int_vec_sel_d;
  logic       nmi_s, irq_s;
  logic       nmi_edge, irq_active, ack_ok;

`ifdef STATUS_SYNC_EN
  logic [1:0] nmi_sync_q, nmi_sync_d;
  logic [1:0] irq_sync_q, irq_sync_d;

  always_comb begin
    nmi_sync_d = {nmi_sync_q[0], nmi_n};
    irq_sync_d = {irq_sync_q[0], irq_n};
  end

  // Synchronizers idle high so a reset never fabricates an NMI edge or IRQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_sync_q <= 2'b11;
      irq_sync_q <= 2'b11;
    end else begin
      nmi_sync_q <= nmi_sync_d;
      irq_sync_q <= irq_sync_d;
    end
  end

  assign nmi_s = nmi_sync_q[1];
  assign irq_s = irq_sync_q[1];
`else
  assign nmi_s = nmi_n;
  assign irq_s = irq_n;
`endif

  always_comb begin
    ack_ok     = (state_q == REQ) & int_ack;
    nmi_edge   = nmi_q & ~nmi_s;
    irq_active = ~irq_s & ~p_q[2];

    p_upd = pl_load ? pl_data : ((p_q & ~flags_ena) | (flags_out & flags_ena));
    p_d   = (p_upd & P_WMASK) | P_ONES;
    // Interrupt entry sets I and clears D regardless of any concurrent write.
    if (ack_ok) begin
      p_d[2] = 1'b1;
      p_d[3] = 1'b0;
    end

    nmi_d      = nmi_s;
    nmi_pend_d = nmi_pend_q;
    if (nmi_edge)
      nmi_pend_d = 1'b1;
    else if (ack_ok & int_vec_sel_q)
      nmi_pend_d = 1'b0;

    state_d       = state_q;
    int_vec_sel_d = int_vec_sel_q;
    case (state_q)
      IDLE: begin
        if (instr_done & (nmi_pend_q | irq_active)) begin
          state_d       = REQ;
          int_vec_sel_d = nmi_pend_q;
        end
      end
      REQ: begin
        if (int_ack)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      p_q           <= P_RESET;
      nmi_q         <= 1'b1;
      nmi_pend_q    <= 1'b0;
      int_vec_sel_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      p_q           <= p_d;
      nmi_q         <= nmi_d;
      nmi_pend_q    <= nmi_pend_d;
      int_vec_sel_q <= int_vec_sel_d;
    end
  end

  assign flags_in    = p_q;
  assign push_data   = {p_q[7], p_q[6], 1'b1, brk_push, p_q[3:0]};
  assign int_req     = (state_q == REQ);
  assign int_vec_sel = int_vec_sel_q;

endmodule

// File: doc/status_register.md
STATUS_REGISTER -- requirements
Module: status_register

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 flags_out  input  8  ALU-computed flag values, bit order N V 1 B D I Z C (bit7..bit0).
REQ-004 flags_ena  input  8  ALU per-bit write enables; bit i set loads flags_out[i].
REQ-005 pl_load  input  1  load P from pl_data (PLP, RTI pull cycle).
REQ-006 pl_data  input  8  pulled status byte.
REQ-007 brk_push  input  1  1 = push image carries B=1 (BRK/PHP); 0 = hardware interrupt push.
REQ-008 nmi_n  input  1  non-maskable interrupt, falling-edge sensitive.
REQ-009 irq_n  input  1  maskable interrupt, level sensitive, active low.
REQ-010 instr_done  input  1  one-cycle pulse at the instruction boundary.
REQ-011 int_ack  input  1  one-cycle pulse: sequencer has accepted the pending interrupt.
REQ-012 flags_in  output  8  current P to ALU and sequencer.
REQ-013 push_data  output  8  status byte for stack push.
REQ-014 int_req  output  1  registered interrupt request to sequencer.
REQ-015 int_vec_sel  output  1  registered; 1 = NMI vector, 0 = IRQ/BRK vector.

Function
REQ-016 P register bits 5 and 4 SHALL always read as 1 on flags_in; no write changes them.
REQ-017 Per-bit update: P[i] <= flags_ena[i] ? flags_out[i] : P[i]; result visible on flags_in the cycle after the write.
REQ-018 pl_load SHALL load P[7:6] and P[3:0] from pl_data and ignore flags_ena in that cycle (pl_load wins).
REQ-019 push_data SHALL be combinational: {P[7], P[6], 1, brk_push, P[3:0]}.
REQ-020 NMI edge detector: nmi_q holds the previous nmi_n sample (reset 1); nmi_q=1 and nmi_n=0 SHALL set nmi_pend on that clock edge.
REQ-021 irq_active = ~irq_n & ~P[2], using P as currently registered.
REQ-022 int_req is a two-state FSM: IDLE -> REQ when instr_done=1 and (nmi_pend | irq_active); REQ -> IDLE on int_ack.
REQ-023 On IDLE->REQ: int_vec_sel <= nmi_pend (NMI has priority over IRQ); int_vec_sel holds while in REQ.
REQ-024 In REQ, deassertion of irq_n SHALL NOT withdraw int_req; the request stands until int_ack.
REQ-025 On int_ack with int_vec_sel=1: nmi_pend cleared; a new NMI edge in the same cycle keeps nmi_pend set.
REQ-026 On int_ack: P[2] <= 1 and P[3] <= 0, overriding flags_ena and pl_load for those bits in the same cycle.
REQ-027 int_ack while IDLE SHALL be ignored (no state or flag change).
REQ-028 instr_done in REQ SHALL have no effect.

Reset
REQ-029 rst_n low SHALL immediately force P=8'h34 (I=1, D=0, N=V=Z=C=0), nmi_q=1, nmi_pend=0, FSM=IDLE, int_req=0, int_vec_sel=0.
REQ-030 Reset mid-request SHALL discard any pending NMI/IRQ; after release, the first request requires a new NMI edge or an unmasked IRQ.

Configuration
REQ-031 Macro STATUS_SYNC_EN: when defined, nmi_n and irq_n each pass through a two-flop synchronizer (reset value 1) before edge detection and masking, adding 2 cycles of input latency; when undefined, pins feed the logic directly.

Verification
REQ-032 Reset release -> flags_in=8'h34, push_data with brk_push=1 = 8'h34, int_req=0.
REQ-033 flags_ena=8'hC3, flags_out=8'hFF, with pl_load=1 and pl_data=8'h00 in the same cycle -> next cycle flags_in=8'h30; next cycle flags_ena=8'hC3, flags_out=8'hFF -> flags_in=8'hF3.
REQ-034 P=8'h30, irq_n=0, instr_done pulse -> int_req=1 next cycle, int_vec_sel=0. Raise irq_n -> int_req stays 1. int_ack -> int_req=0, flags_in=8'h34.
REQ-035 P=8'h34 (I=1), irq_n=0, NMI falling edge, then instr_done -> int_req=1, int_vec_sel=1. int_ack -> nmi_pend=0. Next instr_done -> no request (IRQ masked).
REQ-036 NMI edge coincident with int_ack of a prior NMI -> int_req drops. Next instr_done -> int_req=1, int_vec_sel=1.
REQ-037 rst_n pulsed low while int_req=1 -> int_req=0 asynchronously. After release, instr_done -> int_req stays 0. With STATUS_SYNC_EN defined, repeat REQ-034 -> int_req asserts 2 cycles later.
